// File: rtl/passcode_comparator.sv
// Six-digit BCD keypad passcode checker: captures key press events, either
// programs a new stored code or compares entered digits against it.
module passcode_comparator #(
    parameter logic [23:0] DEFAULT_CODE = 24'h000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_pressed,
    input  logic [3:0] bcd,
    input  logic       clear,
    input  logic       initialize,
    output logic [2:0] digit_count,
    output logic [5:0] cs,
    output logic [5:0] passward_led,
    output logic       correct
);

    logic        key_prev_r;
    logic [23:0] code_r;
    logic        mismatch_r;

    logic        press_s;
    logic        accept_s;
    logic [3:0]  stored_digit_s;
    logic        mismatch_next_s;
    logic [23:0] code_next_s;

    // Rising edge of the key level; a held key yields a single event.
    always_comb begin
        press_s  = key_pressed & ~key_prev_r;
        accept_s = press_s & (digit_count < 3'd6) & (bcd <= 4'd9) & ~clear;
    end

    // Stored digit for the slot the next accepted digit lands in.
    always_comb begin
        stored_digit_s = 4'h0;
        case (digit_count)
            3'd0:    stored_digit_s = code_r[3:0];
            3'd1:    stored_digit_s = code_r[7:4];
            3'd2:    stored_digit_s = code_r[11:8];
            3'd3:    stored_digit_s = code_r[15:12];
            3'd4:    stored_digit_s = code_r[19:16];
            3'd5:    stored_digit_s = code_r[23:20];
            default: stored_digit_s = 4'h0;
        endcase
        mismatch_next_s = mismatch_r | (bcd != stored_digit_s);
    end

    // Stored code with the current slot replaced by the entered digit.
    always_comb begin
        code_next_s = code_r;
        for (int k = 0; k < 6; k++) begin
            if (digit_count == 3'(k)) begin
                code_next_s[k*4 +: 4] = bcd;
            end else begin
                code_next_s[k*4 +: 4] = code_r[k*4 +: 4];
            end
        end
    end

    // One-hot slot select; all zero once six digits are in.
    always_comb begin
        cs = 6'b000000;
        case (digit_count)
            3'd0:    cs = 6'b000001;
            3'd1:    cs = 6'b000010;
            3'd2:    cs = 6'b000100;
            3'd3:    cs = 6'b001000;
            3'd4:    cs = 6'b010000;
            3'd5:    cs = 6'b100000;
            default: cs = 6'b000000;
        endcase
    end

    // Entry state: reset beats clear, clear beats a simultaneous press.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev_r   <= 1'b0;
            code_r       <= DEFAULT_CODE;
            mismatch_r   <= 1'b0;
            digit_count  <= 3'd0;
            passward_led <= 6'b000000;
            correct      <= 1'b0;
        end else begin
            key_prev_r <= key_pressed;
            if (clear) begin
                mismatch_r   <= 1'b0;
                digit_count  <= 3'd0;
                passward_led <= 6'b000000;
                correct      <= 1'b0;
            end else if (accept_s) begin
                digit_count  <= digit_count + 3'd1;
                passward_led <= {passward_led[4:0], 1'b1};
                if (initialize) begin
                    code_r <= code_next_s;
                end else begin
                    mismatch_r <= mismatch_next_s;
                    // Sixth digit decides the verdict, including its own compare.
                    if ((digit_count == 3'd5) && !mismatch_next_s) begin
                        correct <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_passcode_comparator.sv
// Directed self-checking bench for passcode_comparator.
module tb_passcode_comparator;

    logic       clk;
    logic       reset;
    logic       key_pressed;
    logic [3:0] bcd;
    logic       clear;
    logic       initialize;
    logic [2:0] digit_count;
    logic [5:0] cs;
    logic [5:0] passward_led;
    logic       correct;

    int checks = 0;
    int fails  = 0;

    passcode_comparator #(.DEFAULT_CODE(24'h000000)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_pressed  (key_pressed),
        .bcd          (bcd),
        .clear        (clear),
        .initialize   (initialize),
        .digit_count  (digit_count),
        .cs           (cs),
        .passward_led (passward_led),
        .correct      (correct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One idle cycle with the key up, then one cycle with it down; returns #1 after the press edge.
    task automatic press(input logic [3:0] d);
        key_pressed = 1'b0;
        @(posedge clk); #1;
        key_pressed = 1'b1;
        bcd = d;
        @(posedge clk); #1;
        key_pressed = 1'b0;
    endtask

    task automatic enter(input logic [23:0] code);
        for (int i = 0; i < 6; i++) press(code[i*4 +: 4]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; key_pressed = 1'b0; bcd = 4'd0; clear = 1'b0; initialize = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_count", 32'(digit_count), 32'd0);
        check("rst_led", 32'(passward_led), 32'h00);
        check("rst_correct", 32'(correct), 32'd0);
        check("rst_cs", 32'(cs), 32'h01);
        reset = 1'b0;

        // Default code 000000, each accept advances count and thermometer
        for (int i = 0; i < 6; i++) begin
            press(4'd0);
            check("step_count", 32'(digit_count), 32'(i + 1));
            check("step_led", 32'(passward_led), (32'd1 << (i + 1)) - 32'd1);
            if (i == 4) check("corr_before6", 32'(correct), 32'd0);
        end
        check("def_correct", 32'(correct), 32'd1);
        check("def_cs", 32'(cs), 32'h00);

        // Seventh key ignored, correct holds
        press(4'd1);
        check("sat_count", 32'(digit_count), 32'd6);
        check("sat_led", 32'(passward_led), 32'h3f);
        check("sat_correct", 32'(correct), 32'd1);
        do_clear();
        check("clr_count", 32'(digit_count), 32'd0);
        check("clr_led", 32'(passward_led), 32'h00);
        check("clr_correct", 32'(correct), 32'd0);
        check("clr_cs", 32'(cs), 32'h01);

        // Program 1..6, then verify good and bad entries
        initialize = 1'b1;
        enter(24'h654321);
        check("prog_correct", 32'(correct), 32'd0);
        check("prog_count", 32'(digit_count), 32'd6);
        do_clear();
        initialize = 1'b0;
        enter(24'h654321);
        check("good_correct", 32'(correct), 32'd1);
        do_clear();
        enter(24'h754321);
        check("bad_correct", 32'(correct), 32'd0);
        check("bad_count", 32'(digit_count), 32'd6);
        do_clear();

        // Held key counts once; non-BCD value ignored
        key_pressed = 1'b0;
        @(posedge clk); #1;
        key_pressed = 1'b1; bcd = 4'd5;
        repeat (10) @(posedge clk);
        #1;
        key_pressed = 1'b0;
        check("hold_count", 32'(digit_count), 32'd1);
        press(4'd12);
        check("nonbcd_count", 32'(digit_count), 32'd1);
        check("nonbcd_led", 32'(passward_led), 32'h01);
        do_clear();

        // Clear coincident with a press after 3 digits
        press(4'd1); press(4'd2); press(4'd3);
        check("pre_clr_count", 32'(digit_count), 32'd3);
        key_pressed = 1'b0;
        @(posedge clk); #1;
        key_pressed = 1'b1; bcd = 4'd4; clear = 1'b1;
        @(posedge clk); #1;
        key_pressed = 1'b0; clear = 1'b0;
        check("clrpress_count", 32'(digit_count), 32'd0);
        check("clrpress_led", 32'(passward_led), 32'h00);
        press(4'd1);
        check("after_clr_cs", 32'(cs), 32'h02);
        do_clear();

        // Reset mid-programming restores the default code
        initialize = 1'b1;
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst2_count", 32'(digit_count), 32'd0);
        check("rst2_led", 32'(passward_led), 32'h00);
        check("rst2_cs", 32'(cs), 32'h01);
        initialize = 1'b0;
        enter(24'h000000);
        check("rst2_correct", 32'(correct), 32'd1);
        do_clear();

        // initialize switched mid-entry: last three slots programmed to 4,5,6
        press(4'd0); press(4'd0); press(4'd0);
        initialize = 1'b1;
        press(4'd4); press(4'd5); press(4'd6);
        check("mix_correct", 32'(correct), 32'd0);
        do_clear();
        initialize = 1'b0;
        enter(24'h654000);
        check("mix_verify", 32'(correct), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
